// File: rtl/oserdes2_fr_tx_gearbox_if.sv
// Sample-word handshake from the source plus the byte streams to the OSERDES2 pairs.
// Latency: none (wires only).
// Backpressure: din is held by the source until din_valid && din_ready.
interface oserdes2_fr_tx_gearbox_if;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  data_q;
    logic [7:0]  frame_q;

    // Sample source side: drives words, observes acceptance and line bytes.
    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  data_q,
        input  frame_q
    );

    // Gearbox side.
    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output data_q,
        output frame_q
    );
endinterface

// File: rtl/oserdes2_fr_tx_gearbox.sv
// Splits 16-bit samples into MSB-first bytes for a data-lane OSERDES2 pair, plus frame bytes, training and slip.
// Latency: a word accepted at edge E yields its high byte after E+2 and its low byte after E+3.
// Backpressure: din_ready only on word-boundary cycles in DATA; missing words are replaced by IDLE_WORD and counted.
module oserdes2_fr_tx_gearbox #(
    parameter logic [15:0] TRAIN_WORD  = 16'hF0F0,
    parameter logic [15:0] IDLE_WORD   = 16'h0000,
    parameter int unsigned TRAIN_WORDS = 64
) (
    input  logic                         clkdiv,
    input  logic                         reset,
    input  logic                         tx_en,
    input  logic                         train_req,
    input  logic                         reva_flag,
    input  logic [2:0]                   slip,
    output logic                         training,
    output logic [7:0]                   underflow_cnt,
    oserdes2_fr_tx_gearbox_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    localparam logic [15:0] TRAIN_LOAD = 16'(TRAIN_WORDS - 1);

    state_t      state;
    logic        ph;
    logic [15:0] cnt;
    logic [15:0] word_reg;
    logic [7:0]  raw;
    logic [7:0]  raw_frame;
    // Only the low 7 bits of the previous byte can reach the output, since slip tops out at 7.
    logic [6:0]  prev_raw;
    logic [14:0] slip_win;
    logic [7:0]  slip_x;
    logic        accept;

    assign bus.din_ready = ph && (state == ST_DATA) && tx_en && !train_req;
    assign accept        = bus.din_ready && bus.din_valid;

    // Serial order is prev_raw then raw, MSB first; shifting right by slip delays the lane by slip bits.
    assign slip_win = {prev_raw, raw};
    assign slip_x   = slip_win[slip +: 8];

    // Byte phase: ph == 1 marks the edge that closes a word slot.
    always_ff @(posedge clkdiv) begin
        if (reset) begin
            ph <= 1'b0;
        end else begin
            ph <= ~ph;
        end
    end

    // Link state machine; transitions and the training flag only move on word boundaries.
    always_ff @(posedge clkdiv) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 16'd0;
            training <= 1'b0;
        end else if (ph) begin
            case (state)
                ST_IDLE: begin
                    if (train_req) begin
                        state    <= ST_TRAIN;
                        cnt      <= TRAIN_LOAD;
                        training <= 1'b1;
                    end else if (tx_en) begin
                        state <= ST_DATA;
                    end
                end
                ST_TRAIN: begin
                    // A burst always runs to completion; train_req is not looked at here.
                    if (cnt == 16'd0) begin
                        state    <= tx_en ? ST_DATA : ST_IDLE;
                        training <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (train_req) begin
                        state    <= ST_TRAIN;
                        cnt      <= TRAIN_LOAD;
                        training <= 1'b1;
                    end else if (!tx_en) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    training <= 1'b0;
                end
            endcase
        end
    end

    // Word register: loaded from the state held before any transition on the same edge.
    always_ff @(posedge clkdiv) begin
        if (reset) begin
            word_reg      <= IDLE_WORD;
            underflow_cnt <= 8'h00;
        end else if (ph) begin
            case (state)
                ST_DATA: begin
                    if (accept) begin
                        word_reg <= bus.din;
                    end else begin
                        word_reg <= IDLE_WORD;
                        if (underflow_cnt != 8'hFF) begin
                            underflow_cnt <= underflow_cnt + 8'h01;
                        end
                    end
                end
                ST_TRAIN: word_reg <= TRAIN_WORD;
                default:  word_reg <= IDLE_WORD;
            endcase
        end
    end

    // Stage 1: pick the byte of the current word and the matching frame byte.
    always_ff @(posedge clkdiv) begin
        if (reset) begin
            raw       <= 8'h00;
            raw_frame <= 8'h00;
            prev_raw  <= 7'h00;
        end else begin
            raw       <= ph ? word_reg[7:0] : word_reg[15:8];
            raw_frame <= ph ? 8'h00 : 8'hFF;
            prev_raw  <= raw[6:0];
        end
    end

    // Stage 2: apply bit delay then optional inversion to the data lane; frame lane passes straight through.
    always_ff @(posedge clkdiv) begin
        if (reset) begin
            bus.data_q  <= 8'h00;
            bus.frame_q <= 8'h00;
        end else begin
            bus.data_q  <= reva_flag ? ~slip_x : slip_x;
            bus.frame_q <= raw_frame;
        end
    end

endmodule

// File: tb/tb_oserdes2_fr_tx_gearbox.sv
module tb_oserdes2_fr_tx_gearbox;

    localparam int TW = 4;

    logic       clkdiv = 1'b0;
    logic       reset = 1'b1;
    logic       tx_en = 1'b0;
    logic       train_req = 1'b0;
    logic       reva_flag = 1'b0;
    logic [2:0] slip = 3'd0;
    logic       training;
    logic [7:0] underflow_cnt;

    oserdes2_fr_tx_gearbox_if bus ();

    oserdes2_fr_tx_gearbox #(
        .TRAIN_WORD  (16'hF0F0),
        .IDLE_WORD   (16'h0000),
        .TRAIN_WORDS (TW)
    ) dut (
        .clkdiv        (clkdiv),
        .reset         (reset),
        .tx_en         (tx_en),
        .train_req     (train_req),
        .reva_flag     (reva_flag),
        .slip          (slip),
        .training      (training),
        .underflow_cnt (underflow_cnt),
        .bus           (bus)
    );

    always #5 clkdiv = ~clkdiv;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic [7:0] f;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [7:0] exp_hi = 8'h00;
    logic [7:0] exp_lo = 8'h00;
    bit   push_en = 1'b1;
    bit   last_acc = 1'b0;

    // Edge counter: at a negedge, cyc equals the number of rising edges so far.
    always @(posedge clkdiv) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [7:0] d, input logic [7:0] f);
        exp_t e;
        e.cyc = c;
        e.d   = d;
        e.f   = f;
        sbq.push_back(e);
    endtask

    // Expected idle/frame bytes after a reset released at cycle r: frame FF on even offsets.
    task automatic push_pattern(input int r, input int k0, input int k1, input logic [7:0] d);
        for (int k = k0; k <= k1; k++) push(r + k, d, (k % 2 == 0) ? 8'hFF : 8'h00);
    endtask

    // One cycle: inputs set earlier apply to the next rising edge (cyc+1).
    task automatic step();
        @(negedge clkdiv);
        #1;
        last_acc = bus.din_valid && bus.din_ready;
        if (push_en && last_acc) begin
            push(cyc + 3, exp_hi, 8'hFF);
            push(cyc + 4, exp_lo, 8'h00);
        end
    endtask

    task automatic do_reset(output int r);
        reset = 1'b1;
        tx_en = 1'b0;
        train_req = 1'b0;
        bus.din_valid = 1'b0;
        repeat (3) step();
        chk("rst_data_q", int'(bus.data_q), 0);
        chk("rst_frame_q", int'(bus.frame_q), 0);
        chk("rst_din_ready", int'(bus.din_ready), 0);
        chk("rst_training", int'(training), 0);
        chk("rst_underflow", int'(underflow_cnt), 0);
        reset = 1'b0;
        r = cyc;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() > 0; i++) step();
        chk("drain_empty", sbq.size(), 0);
    endtask

    // Monitor: compare the DUT bytes against the queued expectation for this cycle.
    always @(negedge clkdiv) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_slot: entry for cycle %0d unchecked, now %0d", sbq[0].cyc, cyc);
            void'(sbq.pop_front());
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            m_e = sbq.pop_front();
            chk("data_q", int'(bus.data_q), int'(m_e.d));
            chk("frame_q", int'(bus.frame_q), int'(m_e.f));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int b;
        int nacc;
        bus.din = 16'h0000;
        bus.din_valid = 1'b0;

        // Reset and frame pattern with transmission disabled.
        do_reset(r);
        push_pattern(r, 1, 8, 8'h00);
        repeat (8) begin
            step();
            chk("idle_din_ready", int'(bus.din_ready), 0);
        end
        drain();

        // Continuous data A55A.
        do_reset(r);
        tx_en = 1'b1; bus.din = 16'hA55A; bus.din_valid = 1'b1;
        exp_hi = 8'hA5; exp_lo = 8'h5A;
        push_pattern(r, 1, 5, 8'h00);
        repeat (16) step();
        chk("data_underflow", int'(underflow_cnt), 0);
        tx_en = 1'b0; bus.din_valid = 1'b0;
        drain();

        // Slip by 3 bits.
        do_reset(r);
        slip = 3'd3;
        tx_en = 1'b1; bus.din = 16'hFF00; bus.din_valid = 1'b1;
        exp_hi = 8'h1F; exp_lo = 8'hE0;
        repeat (12) step();
        tx_en = 1'b0; bus.din_valid = 1'b0;
        drain();

        // Slip by 3 bits plus lane inversion.
        do_reset(r);
        slip = 3'd3; reva_flag = 1'b1;
        tx_en = 1'b1; bus.din = 16'hFF00; bus.din_valid = 1'b1;
        exp_hi = 8'hE0; exp_lo = 8'h1F;
        repeat (12) step();
        tx_en = 1'b0; bus.din_valid = 1'b0;
        drain();
        slip = 3'd0; reva_flag = 1'b0;

        // Training burst requested from DATA.
        do_reset(r);
        tx_en = 1'b1; bus.din = 16'hA55A; bus.din_valid = 1'b1;
        exp_hi = 8'hA5; exp_lo = 8'h5A;
        nacc = 0;
        for (int i = 0; i < 20 && nacc < 2; i++) begin
            step();
            if (last_acc) nacc++;
        end
        chk("train_pre_accepts", nacc, 2);
        step();
        train_req = 1'b1;
        step();
        chk("train_pre_training", int'(training), 0);
        step();
        train_req = 1'b0;
        b = cyc;
        chk("train_training_rise", int'(training), 1);
        push(b + 2, 8'h00, 8'hFF);
        push(b + 3, 8'h00, 8'h00);
        for (int k = 4; k <= 11; k++) push(b + k, 8'hF0, (k % 2 == 0) ? 8'hFF : 8'h00);
        repeat (12) begin
            step();
            chk("train_training", int'(training), (cyc <= b + 2 * TW - 1) ? 1 : 0);
        end
        tx_en = 1'b0; bus.din_valid = 1'b0;
        drain();

        // Underflow: DATA with no valid words; counter saturates.
        do_reset(r);
        tx_en = 1'b1; bus.din = 16'h1234; bus.din_valid = 1'b0;
        push_pattern(r, 600, 607, 8'h00);
        while (cyc < r + 620) begin
            step();
            if (cyc == r + 4 + 2 * 9)   chk("uf_count_10", int'(underflow_cnt), 10);
            if (cyc == r + 4 + 2 * 254) chk("uf_count_255", int'(underflow_cnt), 255);
            if (cyc == r + 4 + 2 * 255) chk("uf_saturate", int'(underflow_cnt), 255);
        end
        chk("uf_final", int'(underflow_cnt), 255);
        tx_en = 1'b0;
        drain();

        // Reset one cycle after a word is accepted: its bytes must never appear.
        do_reset(r);
        push_en = 1'b0;
        tx_en = 1'b1; bus.din = 16'h3CC3; bus.din_valid = 1'b1;
        nacc = 0;
        for (int i = 0; i < 10 && nacc == 0; i++) begin
            step();
            if (last_acc) nacc++;
        end
        chk("midrst_accept", nacc, 1);
        step();
        reset = 1'b1; tx_en = 1'b0; bus.din_valid = 1'b0;
        step();
        chk("midrst_data_q", int'(bus.data_q), 0);
        chk("midrst_frame_q", int'(bus.frame_q), 0);
        chk("midrst_din_ready", int'(bus.din_ready), 0);
        chk("midrst_training", int'(training), 0);
        step();
        chk("midrst_data_q2", int'(bus.data_q), 0);
        reset = 1'b0;
        r = cyc;
        push_en = 1'b1;
        push_pattern(r, 1, 10, 8'h00);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
